// File: rtl/tdm_demux8.sv
// Receive end of an 8:1 TDM link: frames serial slot bits 0..7 into a parallel
// byte, using the sync marker on slot 0 to acquire and police frame alignment.
module tdm_demux8 #(
  parameter logic [7:0] RESET_VAL = 8'h00
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       din,
  input  logic       sync,
  output logic [7:0] o,
  output logic [2:0] s,
  output logic       valid,
  output logic       sync_err,
  output logic       locked
);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t     state_q, state_d;
  logic [2:0] s_q, s_d;
  logic [7:0] sh_q, sh_d;
  logic [7:0] o_q, o_d;
  logic       valid_q, valid_d;
  logic       err_q, err_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      s_q     <= 3'd0;
      sh_q    <= 8'h00;
      o_q     <= RESET_VAL;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      s_q     <= s_d;
      sh_q    <= sh_d;
      o_q     <= o_d;
      valid_q <= valid_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    s_d     = s_q;
    sh_d    = sh_q;
    o_d     = o_q;
    valid_d = 1'b0;
    err_d   = 1'b0;
    if (en) begin
      unique case (state_q)
        IDLE: begin
          if (sync) begin
            sh_d[0] = din;
            s_d     = 3'd1;
            state_d = RUN;
          end else begin
            s_d = 3'd0;
          end
        end
        RUN: begin
          if (sync) begin
            // Sync anywhere but slot 0 restarts the frame; it outranks slot-7 completion.
            err_d   = (s_q != 3'd0);
            sh_d[0] = din;
            s_d     = 3'd1;
          end else if (s_q == 3'd0) begin
            err_d   = 1'b1;
            s_d     = 3'd0;
            state_d = IDLE;
          end else if (s_q == 3'd7) begin
            o_d     = {din, sh_q[6:0]};
            valid_d = 1'b1;
            s_d     = 3'd0;
          end else begin
            sh_d[s_q] = din;
            s_d       = s_q + 3'd1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign o        = o_q;
  assign s        = s_q;
  assign valid    = valid_q;
  assign sync_err = err_q;
  assign locked   = (state_q == RUN);

endmodule

// File: tb/tb_tdm_demux8.sv
// Scoreboard bench for tdm_demux8: stimulus queues expected frames/errors,
// a negedge monitor retires them as valid/sync_err pulses appear.
module tb_tdm_demux8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b0;
  logic       din = 1'b0;
  logic       sync = 1'b0;
  logic [7:0] o;
  logic [2:0] s;
  logic       valid;
  logic       sync_err;
  logic       locked;

  int         checks = 0;
  int         errors = 0;
  int         cyc = 0;
  int         exp_err = 0;
  logic [7:0] exp_q[$];
  int         vt[$];

  tdm_demux8 #(.RESET_VAL(8'h00)) dut (
    .clk(clk), .rst(rst), .en(en), .din(din), .sync(sync),
    .o(o), .s(s), .valid(valid), .sync_err(sync_err), .locked(locked)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", n, a, e);
    end
  endtask

  // Monitor: every output pulse must retire one queued expectation.
  always @(negedge clk) begin
    if (valid && sync_err) chk("valid_and_err_together", 1, 0);
    if (valid) begin
      vt.push_back(cyc);
      if (exp_q.size() == 0) chk("unexpected_valid", 1, 0);
      else chk("frame_o", {24'd0, o}, {24'd0, exp_q.pop_front()});
    end
    if (sync_err) begin
      if (exp_err == 0) chk("unexpected_sync_err", 1, 0);
      else begin
        exp_err--;
        checks++;
      end
    end
  end

  task automatic step(input logic e, input logic d, input logic sy);
    en = e; din = d; sync = sy;
    @(posedge clk);
    #1;
  endtask

  task automatic frame(input logic [7:0] b);
    exp_q.push_back(b);
    for (int k = 0; k < 8; k++) step(1'b1, b[k], k == 0);
  endtask

  initial begin
    logic [7:0] b;
    // Reset state
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk("rst_o", {24'd0, o}, 32'h00);
    chk("rst_s", {29'd0, s}, 0);
    chk("rst_locked", {31'd0, locked}, 0);
    chk("rst_valid", {31'd0, valid}, 0);

    // Single frame 1,0,1,1,0,0,1,0 -> 8'h4D
    frame(8'h4D);
    chk("single_s_wrap", {29'd0, s}, 0);
    chk("single_locked", {31'd0, locked}, 1);
    step(1'b0, 1'b0, 1'b0);
    chk("single_o_hold", {24'd0, o}, 32'h4D);

    // Back-to-back frames, pulses 8 cycles apart
    vt.delete();
    frame(8'hA5);
    frame(8'h3C);
    step(1'b0, 1'b0, 1'b0);
    chk("b2b_pulses", vt.size(), 2);
    if (vt.size() == 2) chk("b2b_spacing", vt[1] - vt[0], 8);

    // Gapped enable: s holds on en=0 edges
    b = 8'hF0;
    exp_q.push_back(b);
    for (int k = 0; k < 8; k++) begin
      step(1'b1, b[k], k == 0);
      step(1'b0, ~b[k], 1'b1);
      chk("gap_s_hold", {29'd0, s}, (k + 1) % 8);
    end
    chk("gap_o", {24'd0, o}, 32'hF0);

    // Early sync at s=4, then frame 8'h81
    step(1'b1, 1'b1, 1'b1);
    for (int k = 1; k < 4; k++) step(1'b1, 1'b1, 1'b0);
    chk("early_s4", {29'd0, s}, 4);
    b = 8'h81;
    exp_err++;
    exp_q.push_back(b);
    step(1'b1, b[0], 1'b1);
    chk("early_o_unchanged", {24'd0, o}, 32'hF0);
    chk("early_s_restart", {29'd0, s}, 1);
    for (int k = 1; k < 8; k++) step(1'b1, b[k], 1'b0);
    chk("early_then_81", {24'd0, o}, 32'h81);

    // Missing sync at wrap
    exp_err++;
    step(1'b1, 1'b0, 1'b0);
    chk("nosync_unlocked", {31'd0, locked}, 0);
    step(1'b1, 1'b1, 1'b0);
    chk("idle_s_stays0", {29'd0, s}, 0);

    // Reset mid-frame at s=5
    step(1'b1, 1'b1, 1'b1);
    for (int k = 1; k < 5; k++) step(1'b1, 1'b1, 1'b0);
    chk("pre_rst_s5", {29'd0, s}, 5);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_o", {24'd0, o}, 32'h00);
    chk("async_rst_s", {29'd0, s}, 0);
    chk("async_rst_locked", {31'd0, locked}, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    step(1'b1, 1'b1, 1'b0);
    chk("post_rst_needs_sync", {29'd0, s}, 0);
    chk("post_rst_unlocked", {31'd0, locked}, 0);
    frame(8'h5A);

    repeat (3) step(1'b0, 1'b0, 1'b0);
    chk("frames_outstanding", exp_q.size(), 0);
    chk("errs_outstanding", exp_err, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule

// File: doc/tdm_demux8.md
TDM_DEMUX8 -- requirements
Module: tdm_demux8

Interface
REQ-001 Parameter: RESET_VAL, default 8'h00, value loaded into o on reset.
REQ-002 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 Port: rst  input  1  reset, asynchronous and active-high.
REQ-004 Port: en  input  1  sample enable; din/sync are sampled only on edges where en=1.
REQ-005 Port: din  input  1  serial TDM data bit for the current slot.
REQ-006 Port: sync  input  1  frame marker; high together with the slot-0 bit.
REQ-007 Port: o  output  8  last complete frame; o[k] = bit received in slot k.
REQ-008 Port: s  output  3  slot index the next sampled bit is written to.
REQ-009 Port: valid  output  1  one-cycle pulse; o holds a new frame.
REQ-010 Port: sync_err  output  1  one-cycle pulse on a framing violation.
REQ-011 Port: locked  output  1  high while in RUN state.

Function
REQ-012 The block SHALL be the receive end of an 8:1 time-division mux: serial bits in slot order 0..7 are demultiplexed into o[0]..o[7].
REQ-013 FSM states SHALL be IDLE and RUN only; locked = (state==RUN).
REQ-014 Internal shadow register sh[7:0] SHALL collect bits; o SHALL change only on frame completion or reset.
REQ-015 All transitions below SHALL occur only on edges with en=1; with en=0, state, s, sh, o all hold and valid=sync_err=0.
REQ-016 IDLE, sync=1: sh[0]<=din, s<=1, state<=RUN.
REQ-017 IDLE, sync=0: bit discarded, s stays 0, no error pulse.
REQ-018 RUN, s in 1..6, sync=0: sh[s]<=din, s<=s+1.
REQ-019 RUN, s=7, sync=0: o<={din, sh[6:0]}, valid<=1 for exactly the next cycle, s<=0 (wrap), stay RUN.
REQ-020 RUN, s=0, sync=1: sh[0]<=din, s<=1 (normal back-to-back frame, no gap required).
REQ-021 RUN, s=0, sync=0: sync_err<=1 for one cycle, bit discarded, s<=0, state<=IDLE.
REQ-022 RUN, s in 1..7, sync=1 (early sync): sync_err<=1 for one cycle, partial frame dropped, o unchanged, no valid, sh[0]<=din, s<=1, stay RUN.
REQ-023 Early sync at s=7 SHALL follow REQ-022 (the error takes priority over completion).
REQ-024 Latency: valid and the new o SHALL appear the cycle after the clock edge that samples the slot-7 bit; valid and sync_err are registered outputs.
REQ-025 valid and sync_err SHALL never be high in the same cycle.
REQ-026 Continuous en=1 with correct sync SHALL yield one valid pulse every 8 cycles.

Reset
REQ-027 On rst=1, asynchronously: state=IDLE, s=0, sh=0, o=RESET_VAL, valid=0, sync_err=0, locked=0.
REQ-028 Reset mid-frame SHALL discard the partial frame with no valid pulse; the first frame after reset requires sync.
REQ-029 On the first edge after rst falls, behaviour SHALL be per REQ-016/017.

Verification
REQ-030 Reset: assert rst mid-cycle with no clock -> o=8'h00, s=0, locked=0 immediately.
REQ-031 Single frame: en=1, sync on slot 0, din slots 0..7 = 1,0,1,1,0,0,1,0 -> o=8'h4D, valid high exactly 1 cycle, s=0.
REQ-032 Back-to-back: frames 8'hA5 then 8'h3C with no gap -> two valid pulses 8 cycles apart, o=8'hA5 then 8'h3C.
REQ-033 Gapped enable: frame 8'hF0 with en toggling 1,0,1,0... -> o=8'hF0 after the 8th enabled edge; s holds during en=0.
REQ-034 Early sync at s=4 -> sync_err 1 cycle, o unchanged, and the following 8 bits (8'h81) -> o=8'h81 with valid.
REQ-035 Missing sync at wrap -> sync_err, locked=0; rst during s=5 -> no valid, o=RESET_VAL.
